// File: rtl/mem_responder.sv
// Wait-state memory responder: one request at a time, fixed latency, read-before-write.
// Optional MEM_RESPONDER_ERR_EN flags misaligned or out-of-range addresses as access faults.
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic [31:0]            mem_q [0:(1 << ADDR_BITS) - 1];

  logic                   idle;
  logic                   accept;
  logic                   go_resp;
  logic                   mem_we;
  logic                   acc_write;
  logic                   acc_err;
  logic [ADDR_BITS-1:0]   req_idx;
  logic [ADDR_BITS-1:0]   acc_idx;
  logic [31:0]            acc_wdata;

  assign idle      = (state_q == StIdle);
  assign accept    = idle && req_valid;
  assign req_ready = idle;
  assign rsp_valid = (state_q == StResp);
  assign req_idx   = req_addr[ADDR_BITS+1:2];

  // With zero wait states the array access happens on the accept edge itself,
  // so the live request fields are used instead of the latched copies.
  assign acc_write = idle ? req_write : wr_q;
  assign acc_idx   = idle ? req_idx   : idx_q;
  assign acc_wdata = idle ? req_wdata : wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign go_resp = (state_d == StResp) && (state_q != StResp);
  // Guard against a zero-wait accept seen while reset holds the FSM in idle.
  assign mem_we  = go_resp && acc_write && !acc_err && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
    end else if (go_resp) begin
      rsp_rdata <= acc_err ? 32'h0 : mem_q[acc_idx];
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

`ifdef MEM_RESPONDER_ERR_EN
  logic err_q;
  logic req_err;

  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_BITS+2] != '0);
  assign acc_err = idle ? req_err : err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= req_err;
      end
      if (go_resp) begin
        rsp_err <= acc_err;
      end
    end
  end
`else
  logic unused_addr;

  // Byte offset and upper address bits alias onto the array.
  assign unused_addr = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};
  assign acc_err     = 1'b0;
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a 2-wait-state instance,
// hand sequences for backpressure, mid-access reset and a zero-wait instance.
module tb_mem_responder;

`ifdef MEM_RESPONDER_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid, req_write, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        z_req_valid, z_req_write, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

  int n_tests;
  int n_fail;

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut_z (
    .clk       (clk),
    .reset     (reset),
    .req_valid (z_req_valid),
    .req_write (z_req_write),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .req_ready (z_req_ready),
    .rsp_valid (z_rsp_valid),
    .rsp_ready (z_rsp_ready),
    .rsp_rdata (z_rsp_rdata),
    .rsp_err   (z_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic chk, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.chk = chk; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transaction on the 2-wait instance with rsp_ready=1; junk is driven on
  // req_* (valid held high) while the access is in flight.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic er, output int lat, output logic ok);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    step();
    req_write = ~wr; req_addr = 32'h10; req_wdata = 32'hBADBAD00;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    req_valid = 1'b0;
    rd = rsp_rdata;
    er = rsp_err;
    step();
    ok = !rsp_valid && req_ready;
  endtask

  logic [31:0] rd, held_rdata, w10_final;
  logic        er, ok;
  int          lat, n_acc;

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0;
    z_rsp_ready = 1'b1;

    vecs[0]  = mk(1'b1, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    vecs[1]  = mk(1'b0, 32'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b1, 32'h010, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0);
    vecs[3]  = mk(1'b0, 32'h010, 32'h0,        1'b1, 32'h12345678, 1'b0);
    vecs[4]  = mk(1'b1, 32'h020, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    vecs[5]  = mk(1'b0, 32'h020, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0);
    vecs[6]  = mk(1'b0, 32'h023, 32'h0,        1'b1, ErrEn ? 32'h0 : 32'hCAFEF00D, ErrEn);
    vecs[7]  = mk(1'b1, 32'h008, 32'h11112222, 1'b0, 32'h0, 1'b0);
    vecs[8]  = mk(1'b0, 32'h408, 32'h0,        1'b1, ErrEn ? 32'h0 : 32'h11112222, ErrEn);
    vecs[9]  = mk(1'b1, 32'h3FC, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    vecs[10] = mk(1'b0, 32'h3FC, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0);
    vecs[11] = mk(1'b1, 32'h013, 32'h55667788, 1'b1, ErrEn ? 32'h0 : 32'h12345678, ErrEn);
    vecs[12] = mk(1'b0, 32'h010, 32'h0,        1'b1, ErrEn ? 32'h12345678 : 32'h55667788, 1'b0);
    w10_final = ErrEn ? 32'h12345678 : 32'h55667788;

    // Reset values are visible with no clock edge yet.
    #2;
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset z rsp_valid", {31'b0, z_rsp_valid}, 32'd0);
    step(); step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat, ok);
      check($sformatf("vec%0d latency", i), lat, 32'd2);
      check($sformatf("vec%0d one-cycle rsp", i), {31'b0, ok}, 32'd1);
      check($sformatf("vec%0d rsp_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      if (vecs[i].chk) check($sformatf("vec%0d rsp_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Backpressure: hold rsp_ready low for 5 cycles in RESP.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    check("bp latency", lat, 32'd2);
    held_rdata = rsp_rdata;
    check("bp rdata", held_rdata, w10_final);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d rsp_rdata", i), rsp_rdata, w10_final);
      check($sformatf("bp%0d rsp_err", i), {31'b0, rsp_err}, 32'd0);
      check($sformatf("bp%0d req_ready", i), {31'b0, req_ready}, 32'd0);
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp release rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp release req_ready", {31'b0, req_ready}, 32'd1);

    // Reset in WAIT of a store aborts it; rsp_rdata is nonzero beforehand.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    step();
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst req_ready", {31'b0, req_ready}, 32'd1);
    check("midrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst rsp_rdata", rsp_rdata, 32'h0);
    check("midrst rsp_err", {31'b0, rsp_err}, 32'd0);
    step(); step();
    reset = 1'b0;
    step();
    xact(1'b0, 32'h20, 32'h0, rd, er, lat, ok);
    check("midrst reload rdata", rd, 32'hCAFEF00D);
    check("midrst reload latency", lat, 32'd2);

    // Zero wait states: response in the cycle after accept.
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'h0BADF00D;
    step();
    z_req_valid = 1'b0;
    check("z store rsp_valid", {31'b0, z_rsp_valid}, 32'd1);
    check("z store rsp_err", {31'b0, z_rsp_err}, 32'd0);
    step();
    check("z idle rsp_valid", {31'b0, z_rsp_valid}, 32'd0);
    check("z idle req_ready", {31'b0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1; z_req_write = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (z_req_ready) n_acc++;
      if (z_rsp_valid) check($sformatf("z load%0d rdata", i), z_rsp_rdata, 32'h0BADF00D);
      step();
    end
    z_req_valid = 1'b0;
    check("z accepts in 10 cycles", n_acc, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
